counter_seq_ctrl: RTL and testbench

- Sequencing controller for the team's 4-bit up-counter datapath.
- Adds start/stop/pause control, a programmable prescaler, a programmable terminal count, and one-shot or periodic (auto-reload) modes.
- Drives the count value and a terminal-count pulse to downstream logic.
- Sits between the software/pushbutton control layer and any consumer of po_cnt.

---
 rtl/counter_seq_ctrl_pkg.sv | 17 +
 rtl/prescaler_tick.sv | 36 +++
 rtl/counter_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// rtl/counter_seq_ctrl_pkg.sv - shared state and mode encodings for counter_seq_ctrl
//
// Purpose: state_t FSM encoding (IDLE/RUN/PAUSE/DONE) and counting-mode constants.
// Ports: none (package).
package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prescaler_tick.sv
// rtl/prescaler_tick.sv - programmable prescaler producing one tick every div+1 enabled cycles
//
// Purpose: holds pre_cnt; tick is combinational so the top can act on it in the same cycle.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous reset, active-high
//   en   in  count enable (RUN and not paused); pre_cnt holds when low
//   clr  in  synchronous clear, wins over en
//   div  in  divide value; tick fires when pre_cnt == div
//   tick out one-cycle enable for the counter datapath
module prescaler_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pre_cnt;

  assign tick = en && (pre_cnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (clr || tick) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - start/stop/pause sequencer around a prescaled up-counter
//
// Purpose: FSM, shadowed configuration and count/terminal-count logic.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous reset, active-high
//   start     in  launch from IDLE or DONE (ignored while busy)
//   stop      in  abort to IDLE from any state, highest priority
//   pause     in  hold count while high (RUN/PAUSE)
//   cfg_top   in  terminal count, captured on launch
//   cfg_div   in  prescaler divide value, captured on launch
//   cfg_mode  in  0 one-shot, 1 periodic, captured on launch
//   po_cnt    out current count
//   tc_pulse  out one-cycle pulse when the terminal count is reached
//   busy      out high in RUN or PAUSE
//   done      out high in DONE
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [CNT_W-1:0] cfg_top,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [CNT_W-1:0] po_cnt,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] top_s;
  logic [DIV_W-1:0] div_s;
  logic             mode_s;
  logic             launch;
  logic             run_en;
  logic             tick;
  logic             at_top;

  // start only counts when not busy; stop overrides everything.
  assign launch = !stop && start && (state == ST_IDLE || state == ST_DONE);
  assign run_en = !stop && (state == ST_RUN) && !pause;
  assign at_top = (po_cnt == top_s);

  prescaler_tick #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .clr  (stop || launch),
    .div  (div_s),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state_nx = ST_RUN;
        ST_RUN: begin
          if (pause) begin
            state_nx = ST_PAUSE;
          end else if (tick && at_top && mode_s == MODE_ONESHOT) begin
            state_nx = ST_DONE;
          end
        end
        ST_PAUSE: if (!pause) state_nx = ST_RUN;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // busy/done decode the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_cnt   <= '0;
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      top_s    <= '0;
      div_s    <= '0;
      mode_s   <= MODE_ONESHOT;
    end else begin
      tc_pulse <= 1'b0;
      busy     <= (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
      done     <= (state_nx == ST_DONE);
      if (stop) begin
        po_cnt <= '0;
      end else if (launch) begin
        po_cnt <= '0;
        top_s  <= cfg_top;
        div_s  <= cfg_div;
        mode_s <= cfg_mode;
      end else if (tick) begin
        if (at_top) begin
          tc_pulse <= 1'b1;
          // One-shot keeps top_s on display while parked in DONE.
          if (mode_s == MODE_PERIODIC) po_cnt <= '0;
        end else begin
          po_cnt <= po_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - directed table-driven bench for counter_seq_ctrl
module tb_counter_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] cfg_top;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic [3:0] po_cnt;
  logic       tc_pulse;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  counter_seq_ctrl #(.CNT_W(4), .DIV_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .cfg_top  (cfg_top),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .po_cnt   (po_cnt),
    .tc_pulse (tc_pulse),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] top;
    logic [7:0] div;
    logic       mode;
    logic [3:0] e_cnt;
    logic       e_tc;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic p, input logic pa,
                              input logic [3:0] t, input logic [7:0] d, input logic m,
                              input logic [3:0] c, input logic tc, input logic b,
                              input logic dn);
    vec_t v;
    v.start = s; v.stop = p; v.pause = pa; v.top = t; v.div = d; v.mode = m;
    v.e_cnt = c; v.e_tc = tc; v.e_busy = b; v.e_done = dn;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic pa,
                       input logic [3:0] t, input logic [7:0] d, input logic m);
    start = s; stop = p; pause = pa; cfg_top = t; cfg_div = d; cfg_mode = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 4'd0, 8'd0, 1'b0);

    // periodic top=3 div=0, with a start and a cfg_top change while running
    vq.push_back(mk(1,0,0, 4'd3,8'd0,1, 4'd0,0,1,0));
    vq.push_back(mk(0,0,0, 4'd3,8'd0,1, 4'd1,0,1,0));
    vq.push_back(mk(0,0,0, 4'd3,8'd0,1, 4'd2,0,1,0));
    vq.push_back(mk(1,0,0, 4'd7,8'd0,1, 4'd3,0,1,0));
    vq.push_back(mk(0,0,0, 4'd7,8'd0,1, 4'd0,1,1,0));
    vq.push_back(mk(0,0,0, 4'd7,8'd0,1, 4'd1,0,1,0));
    vq.push_back(mk(0,0,0, 4'd7,8'd0,1, 4'd2,0,1,0));
    vq.push_back(mk(0,0,0, 4'd7,8'd0,1, 4'd3,0,1,0));
    vq.push_back(mk(0,0,0, 4'd7,8'd0,1, 4'd0,1,1,0));
    vq.push_back(mk(0,1,0, 4'd7,8'd0,1, 4'd0,0,0,0));
    // one-shot top=2 div=2: increments every 3 edges, tc 9 edges after start
    vq.push_back(mk(1,0,0, 4'd2,8'd2,0, 4'd0,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd0,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd0,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd1,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd1,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd1,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd2,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd2,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd2,0,1,0));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd2,1,0,1));
    vq.push_back(mk(0,0,0, 4'd2,8'd2,0, 4'd2,0,0,1));
    // start + stop together in DONE: stop wins
    vq.push_back(mk(1,1,0, 4'd2,8'd2,0, 4'd0,0,0,0));
    // start + pause in IDLE: RUN first, PAUSE next edge, one edge to resume, then count
    vq.push_back(mk(1,0,1, 4'd3,8'd0,1, 4'd0,0,1,0));
    vq.push_back(mk(0,0,1, 4'd3,8'd0,1, 4'd0,0,1,0));
    vq.push_back(mk(0,0,0, 4'd3,8'd0,1, 4'd0,0,1,0));
    vq.push_back(mk(0,0,0, 4'd3,8'd0,1, 4'd1,0,1,0));
    vq.push_back(mk(0,1,0, 4'd3,8'd0,1, 4'd0,0,0,0));

    // reset values
    step();
    check("rst_cnt", int'(po_cnt), 0);
    check("rst_tc", int'(tc_pulse), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].stop, vq[i].pause, vq[i].top, vq[i].div, vq[i].mode);
      step();
      check($sformatf("v%0d_cnt", i), int'(po_cnt), int'(vq[i].e_cnt));
      check($sformatf("v%0d_tc", i), int'(tc_pulse), int'(vq[i].e_tc));
      check($sformatf("v%0d_busy", i), int'(busy), int'(vq[i].e_busy));
      check($sformatf("v%0d_done", i), int'(done), int'(vq[i].e_done));
    end

    // asynchronous reset mid-RUN at count 2
    drive(1, 0, 0, 4'd3, 8'd0, 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    check("arst_pre_cnt", int'(po_cnt), 2);
    #3 rst = 1'b1;
    #1;
    check("arst_cnt", int'(po_cnt), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_tc", int'(tc_pulse), 0);
    #1 rst = 1'b0;
    step();
    check("arst_after_busy", int'(busy), 0);

    // pause for 5 edges at count 6, periodic top=15 div=0
    drive(1, 0, 0, 4'd15, 8'd0, 1'b1);
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("pause_pre_cnt", int'(po_cnt), 6);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("pause%0d_cnt", k), int'(po_cnt), 6);
      check($sformatf("pause%0d_state", k), int'(dut.state), 2);
      check($sformatf("pause%0d_busy", k), int'(busy), 1);
    end
    pause = 1'b0;
    step();
    check("resume_state", int'(dut.state), 1);
    check("resume_cnt0", int'(po_cnt), 6);
    step();
    check("resume_cnt1", int'(po_cnt), 7);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // top=0 div=0 periodic: tc every edge, count pinned at 0
    drive(1, 0, 0, 4'd0, 8'd0, 1'b1);
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("top0_%0d_tc", k), int'(tc_pulse), 1);
      check($sformatf("top0_%0d_cnt", k), int'(po_cnt), 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("top0_stop_tc", int'(tc_pulse), 0);
    check("top0_stop_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
